// File: rtl/aurora_axi_pkg.sv
// aurora_axi_pkg: shared widths, FSM encoding and counter sizing for the Aurora RX arbiter
package aurora_axi_pkg;
  localparam int AXIS_DW = 32;
  localparam int AXIS_KW = 4;
  localparam int MAX_CH = 4;
  localparam int IDX_W = 2;
  typedef enum logic {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_e;
  function automatic int tmo_w(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction
endpackage

// File: rtl/aurora_rr_pick.sv
// aurora_rr_pick: rotating priority encoder, first request at or after last+1 wins
module aurora_rr_pick
  import aurora_axi_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             any,
  output logic [IDX_W-1:0] idx
);
  localparam int W = IDX_W + 1;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   off, sum;
  always_comb begin
    dbl = {req, req} >> ({1'b0, last} + 1'b1);
    rot = dbl[N-1:0];
    any = |req;
    off = '0;
    for (int j = N - 1; j >= 0; j--)
      if (rot[j]) off = W'(j);
    sum = off + {1'b0, last} + 1'b1;
    idx = (sum >= W'(N)) ? IDX_W'(sum - W'(N)) : sum[IDX_W-1:0];
  end
endmodule

// File: rtl/aurora_axi_rx_arb.sv
// aurora_axi_rx_arb: packet-locked round-robin merge of up to 4 Aurora RX AXI streams
module aurora_axi_rx_arb
  import aurora_axi_pkg::*;
#(
  parameter int ETHCOUNT = 4,
  parameter int TIMEOUT  = 1024,
  parameter bit SIM      = 1'b0
) (
  input  logic                        clk,
  input  logic                        rstn,
  output logic [ETHCOUNT-1:0]         axis_s_tready,
  input  logic [ETHCOUNT*AXIS_DW-1:0] axis_s_tdata,
  input  logic [ETHCOUNT*AXIS_KW-1:0] axis_s_tkeep,
  input  logic [ETHCOUNT-1:0]         axis_s_tvalid,
  input  logic [ETHCOUNT-1:0]         axis_s_tlast,
  input  logic                        axis_m_tready,
  output logic [AXIS_DW-1:0]          axis_m_tdata,
  output logic [AXIS_KW-1:0]          axis_m_tkeep,
  output logic                        axis_m_tvalid,
  output logic                        axis_m_tlast,
  output logic [2:0]                  sel,
  output logic                        busy,
  output logic                        err_timeout
);
  localparam int TW = tmo_w(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(ETHCOUNT - 1);
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d, last_q, last_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [AXIS_DW-1:0] dat_q, dat_d;
  logic [AXIS_KW-1:0] kep_q, kep_d;
  logic               vld_q, vld_d, lst_q, lst_d, err_q, err_d;
  logic [AXIS_DW-1:0] dat_a [MAX_CH];
  logic [AXIS_KW-1:0] kep_a [MAX_CH];
  logic [MAX_CH-1:0]  vld_x, lst_x, tready_x;
  logic               pick_any, rdy, hs, hs_last, expire;
  logic [IDX_W-1:0]   pick_idx;
  // Pad the source bundle out to MAX_CH so the grant index always has full width
  for (genvar i = 0; i < MAX_CH; i++) begin : g_ch
    if (i < ETHCOUNT) begin : g_on
      assign dat_a[i] = axis_s_tdata[i*AXIS_DW +: AXIS_DW];
      assign kep_a[i] = axis_s_tkeep[i*AXIS_KW +: AXIS_KW];
      assign vld_x[i] = axis_s_tvalid[i];
      assign lst_x[i] = axis_s_tlast[i];
    end else begin : g_off
      assign dat_a[i] = '0;
      assign kep_a[i] = '0;
      assign vld_x[i] = 1'b0;
      assign lst_x[i] = 1'b0;
    end
  end
  aurora_rr_pick #(.N(ETHCOUNT)) u_pick (
    .req (axis_s_tvalid),
    .last(last_q),
    .any (pick_any),
    .idx (pick_idx)
  );
  assign rdy      = (state_q == ST_XFER) && (!vld_q || axis_m_tready);
  assign tready_x = rdy ? (MAX_CH'(1) << grant_q) : '0;
  assign hs       = rdy && vld_x[grant_q];
  assign hs_last  = hs && lst_x[grant_q];
  // A handshake in the expiry cycle wins over the forced release
  assign expire   = (TIMEOUT > 0) && (state_q == ST_XFER) && !hs && (tmo_q == TW'(TIMEOUT - 1));
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    dat_d   = dat_q;
    kep_d   = kep_q;
    lst_d   = lst_q;
    vld_d   = vld_q;
    err_d   = expire;
    if (hs) begin
      dat_d = dat_a[grant_q];
      kep_d = kep_a[grant_q];
      lst_d = lst_x[grant_q];
      vld_d = 1'b1;
    end else if (axis_m_tready) begin
      vld_d = 1'b0;
    end
    if (state_q == ST_IDLE) begin
      tmo_d = '0;
      if (pick_any) begin
        grant_d = pick_idx;
        state_d = ST_XFER;
      end
    end else if (hs_last || expire) begin
      state_d = ST_IDLE;
      last_d  = grant_q;
      tmo_d   = '0;
    end else if (hs) begin
      tmo_d = '0;
    end else if ((TIMEOUT > 0) && !vld_x[grant_q] && (tmo_q != '1)) begin
      tmo_d = tmo_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      tmo_q   <= '0;
      dat_q   <= '0;
      kep_q   <= '0;
      lst_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      dat_q   <= dat_d;
      kep_q   <= kep_d;
      lst_q   <= lst_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end
  assign axis_s_tready = tready_x[ETHCOUNT-1:0];
  assign axis_m_tdata  = dat_q;
  assign axis_m_tkeep  = kep_q;
  assign axis_m_tvalid = vld_q;
  assign axis_m_tlast  = lst_q;
  assign sel           = {1'b0, grant_q};
  assign busy          = (state_q == ST_XFER);
  assign err_timeout   = err_q;
  if (SIM) begin : g_sim
    always @(posedge clk) begin
      if (rstn) begin
        assert ($onehot0(tready_x));
        assert (int'(grant_q) < ETHCOUNT);
        assert (state_q == ST_XFER || tready_x == '0);
      end
    end
  end
endmodule
